qiangda_n: RTL and testbench

//  Parametrised N-player quiz lockout controller: the next generation of the 4-player quiz buzzer.

---
 rtl/qiangda_pkg.sv | 20 ++
 rtl/qd_tick_gen.sv | 30 +++
 rtl/qiangda_n.sv | 203 ++++++++++++++++++++
 tb/tb_qiangda_n.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qiangda_pkg.sv
// Shared definitions for the N-player quiz lockout controller.
package qiangda_pkg;

  // Controller state codes. These are also the values driven on the state output.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_EXPIRED = 2'd3
  } qd_state_e;

  // Width of win_id: 0 = no winner, 1..15 = player number.
  localparam int WIN_W = 4;

  // LSB of the score slice for a 0-based player index.
  function automatic int unsigned score_lsb(input int unsigned idx0, input int unsigned w);
    return idx0 * w;
  endfunction

endpackage

// File: rtl/qd_tick_gen.sv
// Tick prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle.
// A restart puts the count back at 0, so the next tick comes TICK_DIV cycles later.
module qd_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic restart,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] pcnt_q;

  // Free-running prescaler with synchronous restart.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pcnt_q <= '0;
    end else if (restart || (pcnt_q == LAST)) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_q + DIV_W'(1);
    end
  end

  assign tick = (pcnt_q == LAST);

endmodule

// File: rtl/qiangda_n.sv
// N-player quiz lockout controller: armed countdown, first-buzz lockout with
// lowest-index priority, false-start flags, answer timeout and saturating scores.
module qiangda_n
  import qiangda_pkg::*;
#(
  parameter int N_PLAYERS  = 4,
  parameter int SCORE_W    = 4,
  parameter int CNT_W      = 4,
  parameter int CNT_INIT   = 15,
  parameter int TICK_DIV   = 1000,
  parameter int ANS_TICKS  = 10,
  parameter int BEEP_TICKS = 1
) (
  input  logic                         clk,
  input  logic                         clr_n,
  input  logic                         start,
  input  logic                         score_clr,
  input  logic [N_PLAYERS-1:0]         in,
  input  logic                         add,
  input  logic                         sub,
  output logic [WIN_W-1:0]             win_id,
  output logic [CNT_W-1:0]             cnt,
  output logic [N_PLAYERS*SCORE_W-1:0] score,
  output logic [N_PLAYERS-1:0]         false_start,
  output logic [1:0]                   state,
  output logic                         timeout,
  output logic                         Buzzer
);

  localparam int ANS_W  = $clog2(ANS_TICKS + 1);
  localparam int BEEP_W = $clog2(BEEP_TICKS + 1);

  qd_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [N_PLAYERS-1:0] fs_q, fs_d;
  logic [ANS_W-1:0]     ans_q, ans_d;
  logic [BEEP_W-1:0]    beep_q, beep_d;
  logic                 buzzer_q, buzzer_d;
  logic                 timeout_q, timeout_d;
  logic [SCORE_W-1:0]   score_q [N_PLAYERS];

  logic [N_PLAYERS-1:0] eligible;
  logic [WIN_W-1:0]     first_id;
  logic                 beep_trig, do_add, do_sub, clr_scores;
  logic                 tick, restart;

  // Prescaler restarts on any state change or new beep so every timed interval is whole ticks.
  qd_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .clr_n   (clr_n),
    .restart (restart),
    .tick    (tick)
  );

  // Next-state, countdown, timers and flags; score_clr overrides every state action.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    win_d      = win_q;
    fs_d       = fs_q;
    ans_d      = ans_q;
    timeout_d  = 1'b0;
    beep_trig  = 1'b0;
    do_add     = 1'b0;
    do_sub     = 1'b0;
    clr_scores = 1'b0;
    eligible   = in & ~fs_q;
    first_id   = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (eligible[i]) first_id = WIN_W'(i + 1);
    end
    if (score_clr) begin
      state_d    = ST_IDLE;
      cnt_d      = CNT_W'(CNT_INIT);
      win_d      = '0;
      fs_d       = '0;
      ans_d      = '0;
      clr_scores = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in != '0) begin
            fs_d      = fs_q | in;
            beep_trig = 1'b1;
          end
          if (start) begin
            cnt_d   = CNT_W'(CNT_INIT);
            win_d   = '0;
            state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (eligible != '0) begin
            win_d     = first_id;
            ans_d     = ANS_W'(ANS_TICKS);
            state_d   = ST_LOCKED;
            beep_trig = 1'b1;
          end else if (tick) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d   = ST_EXPIRED;
              beep_trig = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (add ^ sub) begin
            do_add  = add;
            do_sub  = sub;
            state_d = ST_IDLE;
            fs_d    = '0;
          end else if (tick) begin
            if (ans_q == ANS_W'(1)) begin
              timeout_d = 1'b1;
              state_d   = ST_IDLE;
              fs_d      = '0;
            end else begin
              ans_d = ans_q - ANS_W'(1);
            end
          end
        end
        default: begin
          win_d = '0;
          cnt_d = '0;
          if (start) begin
            cnt_d   = CNT_W'(CNT_INIT);
            state_d = ST_ARMED;
            fs_d    = '0;
          end
        end
      endcase
    end
    restart = (state_d != state_q) || beep_trig || score_clr;
  end

  // Beep timer: a trigger (re)loads it and drives the buzzer low until it runs out.
  always_comb begin
    beep_d   = beep_q;
    buzzer_d = buzzer_q;
    if (score_clr) begin
      beep_d   = '0;
      buzzer_d = 1'b1;
    end else if (beep_trig) begin
      beep_d   = BEEP_W'(BEEP_TICKS);
      buzzer_d = 1'b0;
    end else if (tick && (beep_q != '0)) begin
      beep_d = beep_q - BEEP_W'(1);
      if (beep_q == BEEP_W'(1)) buzzer_d = 1'b1;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_W'(CNT_INIT);
      win_q     <= '0;
      fs_q      <= '0;
      ans_q     <= '0;
      beep_q    <= '0;
      buzzer_q  <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      fs_q      <= fs_d;
      ans_q     <= ans_d;
      beep_q    <= beep_d;
      buzzer_q  <= buzzer_d;
      timeout_q <= timeout_d;
    end
  end

  // Saturating per-player scores, updated for the locked player on a ruling.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
    end else if (clr_scores) begin
      for (int i = 0; i < N_PLAYERS; i++) score_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (win_q == WIN_W'(i + 1)) begin
          if (do_add && (score_q[i] != '1)) score_q[i] <= score_q[i] + SCORE_W'(1);
          else if (do_sub && (score_q[i] != '0)) score_q[i] <= score_q[i] - SCORE_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < N_PLAYERS; k++) begin : g_score
    assign score[score_lsb(k, SCORE_W) +: SCORE_W] = score_q[k];
  end

  assign win_id      = win_q;
  assign cnt         = cnt_q;
  assign false_start = fs_q;
  assign state       = state_q;
  assign timeout     = timeout_q;
  assign Buzzer      = buzzer_q;

endmodule

// File: tb/tb_qiangda_n.sv
// Directed bench for qiangda_n with a score scoreboard.
module tb_qiangda_n;

  localparam int N = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          clr_n;
  logic          start, score_clr, add, sub;
  logic [N-1:0]  in;
  logic [3:0]    win_id;
  logic [3:0]    cnt;
  logic [N*SW-1:0] score;
  logic [N-1:0]  false_start;
  logic [1:0]    state;
  logic          timeout;
  logic          Buzzer;

  int n_assert = 0;
  int n_fail   = 0;
  logic [N*SW-1:0] exp_q[$];
  int exp_score [N];

  qiangda_n #(
    .N_PLAYERS(N), .SCORE_W(SW), .CNT_W(4), .CNT_INIT(3),
    .TICK_DIV(4), .ANS_TICKS(2), .BEEP_TICKS(1)
  ) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .score_clr(score_clr), .in(in),
    .add(add), .sub(sub), .win_id(win_id), .cnt(cnt), .score(score),
    .false_start(false_start), .state(state), .timeout(timeout), .Buzzer(Buzzer)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [N*SW-1:0] pack_scores();
    logic [N*SW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*SW +: SW] = SW'(exp_score[k]);
    return v;
  endfunction

  // Scoreboard: pop the expected score vector and compare.
  task automatic sb_check(input string tag, input logic [N*SW-1:0] obs);
    logic [N*SW-1:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected <empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  // One full round: arm, player k (1-based) buzzes, judge rules with add_v/sub_v.
  task automatic round(input int k, input logic add_v, input logic sub_v);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    in = N'(1) << (k - 1);
    cyc(1);
    chk("round_win_id", win_id, k);
    in = '0;
    add = add_v;
    sub = sub_v;
    if (add_v && exp_score[k-1] < 15) exp_score[k-1]++;
    if (sub_v && exp_score[k-1] > 0) exp_score[k-1]--;
    exp_q.push_back(pack_scores());
    cyc(1);
    add = 1'b0;
    sub = 1'b0;
    sb_check("round_score", score);
    chk("round_state_idle", state, 0);
  endtask

  initial begin
    int c;
    clr_n = 1'b0; start = 1'b0; score_clr = 1'b0; add = 1'b0; sub = 1'b0; in = '0;
    for (int k = 0; k < N; k++) exp_score[k] = 0;
    cyc(2);
    chk("rst_state", state, 0);
    chk("rst_win_id", win_id, 0);
    chk("rst_cnt", cnt, 3);
    chk("rst_score", score, 0);
    chk("rst_false_start", false_start, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_buzzer", Buzzer, 1);
    clr_n = 1'b1;
    cyc(1);

    // 1: countdown to expiry with no buzz.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("t1_armed", state, 1);
    chk("t1_cnt3", cnt, 3);
    cyc(3);
    chk("t1_cnt3_hold", cnt, 3);
    cyc(1);
    chk("t1_cnt2", cnt, 2);
    cyc(4);
    chk("t1_cnt1", cnt, 1);
    cyc(4);
    chk("t1_cnt0", cnt, 0);
    chk("t1_expired", state, 3);
    chk("t1_beep_on", Buzzer, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t1_beep_hold", Buzzer, 0);
    end
    cyc(1);
    chk("t1_beep_off", Buzzer, 1);
    in = 4'b0001;
    cyc(1);
    in = '0;
    chk("t1_exp_ignore_fs", false_start, 0);
    chk("t1_exp_ignore_state", state, 3);
    chk("t1_exp_win0", win_id, 0);

    // 2: re-arm from EXPIRED; two players together, lower index wins.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("t2_armed", state, 1);
    chk("t2_cnt", cnt, 3);
    in = 4'b0110;
    cyc(1);
    in = '0;
    chk("t2_win_id", win_id, 2);
    chk("t2_locked", state, 2);
    chk("t2_beep", Buzzer, 0);
    add = 1'b1;
    exp_score[1] = 1;
    exp_q.push_back(pack_scores());
    cyc(1);
    add = 1'b0;
    sb_check("t2_score", score);
    chk("t2_idle", state, 0);
    chk("t2_win_hold", win_id, 2);

    // 3: false start excludes player 1; round end clears the flags.
    in = 4'b0001;
    cyc(1);
    in = '0;
    chk("t3_fs_set", false_start, 4'b0001);
    chk("t3_fs_beep", Buzzer, 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("t3_fs_kept", false_start, 4'b0001);
    in = 4'b0011;
    cyc(1);
    in = '0;
    chk("t3_win_id", win_id, 2);
    sub = 1'b1;
    exp_score[1] = 0;
    exp_q.push_back(pack_scores());
    cyc(1);
    sub = 1'b0;
    sb_check("t3_score", score);
    chk("t3_fs_clear", false_start, 0);

    // 4: saturation at the top and at zero.
    for (int i = 0; i < 16; i++) round(3, 1'b1, 1'b0);
    chk("t4_score3_sat", score[11:8], 15);
    round(1, 1'b0, 1'b1);
    chk("t4_score1_zero", score[3:0], 0);

    // 5: answer timeout.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    in = 4'b1000;
    cyc(1);
    in = '0;
    chk("t5_win_id", win_id, 4);
    chk("t5_locked", state, 2);
    c = 0;
    while (c < 20) begin
      cyc(1);
      c++;
      if (timeout === 1'b1) break;
    end
    chk("t5_timeout_latency", c, 8);
    chk("t5_idle", state, 0);
    cyc(1);
    chk("t5_timeout_pulse", timeout, 0);
    exp_q.push_back(pack_scores());
    sb_check("t5_score", score);

    // 6: add&sub ignored, async reset mid-round, score_clr priority.
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    in = 4'b0001;
    cyc(1);
    in = '0;
    add = 1'b1;
    sub = 1'b1;
    exp_q.push_back(pack_scores());
    cyc(1);
    add = 1'b0;
    sub = 1'b0;
    chk("t6_both_locked", state, 2);
    sb_check("t6_both_score", score);
    add = 1'b1;
    exp_score[0] = 1;
    exp_q.push_back(pack_scores());
    cyc(1);
    add = 1'b0;
    sb_check("t6_add_score", score);

    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("t6_armed", state, 1);
    cyc(2);
    clr_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) exp_score[k] = 0;
    chk("t6_rst_state", state, 0);
    chk("t6_rst_cnt", cnt, 3);
    chk("t6_rst_win", win_id, 0);
    chk("t6_rst_score", score, 0);
    chk("t6_rst_buzzer", Buzzer, 1);
    clr_n = 1'b1;
    cyc(1);

    round(2, 1'b1, 1'b0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    in = 4'b0010;
    cyc(1);
    in = '0;
    add = 1'b1;
    score_clr = 1'b1;
    for (int k = 0; k < N; k++) exp_score[k] = 0;
    exp_q.push_back(pack_scores());
    cyc(1);
    add = 1'b0;
    score_clr = 1'b0;
    sb_check("t6_clr_score", score);
    chk("t6_clr_state", state, 0);
    chk("t6_clr_win", win_id, 0);
    chk("t6_clr_cnt", cnt, 3);
    chk("t6_clr_buzzer", Buzzer, 1);

    // Final report.
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
